// File: rtl/ies_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ies_control_fsm
// Brief    : Multicycle fetch/decode/execute sequencer for the 16-bit IES.
// Revision : 1.0 - initial release
// ============================================================================
module ies_control_fsm #(
    parameter logic [7:0] FETCH_TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] op,
    input  logic       cmp_result,
    input  logic       mem_ready,
    input  logic       run,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCBranch,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegR1,
    output logic       RegR2,
    output logic       RegW1,
    output logic       RegW2,
    output logic       ALUsrc,
    output logic       writeCR,
    output logic       cmpeq,
    output logic       cmpne,
    output logic       backup,
    output logic       restore,
    output logic [1:0] Regsrc,
    output logic [2:0] ALUop,
    output logic       halted,
    output logic       fault
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_SUB   = 4'h1;
    localparam logic [3:0] c_OP_AND   = 4'h2;
    localparam logic [3:0] c_OP_OR    = 4'h3;
    localparam logic [3:0] c_OP_ADDI  = 4'h4;
    localparam logic [3:0] c_OP_LW    = 4'h5;
    localparam logic [3:0] c_OP_SW    = 4'h6;
    localparam logic [3:0] c_OP_SLT   = 4'h7;
    localparam logic [3:0] c_OP_IN    = 4'h8;
    localparam logic [3:0] c_OP_OUT   = 4'h9;
    localparam logic [3:0] c_OP_CMPEQ = 4'hA;
    localparam logic [3:0] c_OP_CMPNE = 4'hB;
    localparam logic [3:0] c_OP_CALL  = 4'hC;
    localparam logic [3:0] c_OP_RET   = 4'hD;
    localparam logic [3:0] c_OP_NOP   = 4'hE;
    localparam logic [3:0] c_OP_HALT  = 4'hF;

    localparam logic [1:0] c_SRC_ALU = 2'b00;
    localparam logic [1:0] c_SRC_IO  = 2'b01;
    localparam logic [1:0] c_SRC_MEM = 2'b10;
    localparam logic [1:0] c_SRC_RA  = 2'b11;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b100;

    logic [2:0] r_state;
    logic [3:0] r_op;
    logic [7:0] r_wait;
    logic       r_fault;

    logic [2:0] w_state_next;
    logic [7:0] w_wait_next;
    logic       w_mem_wait;
    logic       w_timeout;

    // A memory wait is only meaningful in the two states that touch memory.
    assign w_mem_wait = ((r_state == c_FETCH) || (r_state == c_MEM)) && !mem_ready;
    assign w_timeout  = w_mem_wait && (r_wait == (FETCH_TIMEOUT - 8'd1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = c_FETCH;
        case (r_state)
            c_FETCH: begin
                if (mem_ready) begin
                    w_state_next = c_DECODE;
                end else if (w_timeout) begin
                    w_state_next = c_HALT;
                end else begin
                    w_state_next = c_FETCH;
                end
            end
            c_DECODE: begin
                case (op)
                    c_OP_NOP:  w_state_next = c_FETCH;
                    c_OP_HALT: w_state_next = c_HALT;
                    default:   w_state_next = c_EXEC;
                endcase
            end
            c_EXEC: begin
                case (r_op)
                    c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
                    c_OP_ADDI, c_OP_IN:  w_state_next = c_WB;
                    c_OP_LW, c_OP_SW:    w_state_next = c_MEM;
                    default:             w_state_next = c_FETCH;
                endcase
            end
            c_MEM: begin
                if (mem_ready) begin
                    w_state_next = (r_op == c_OP_LW) ? c_WB : c_FETCH;
                end else if (w_timeout) begin
                    w_state_next = c_HALT;
                end else begin
                    w_state_next = c_MEM;
                end
            end
            c_WB: begin
                w_state_next = c_FETCH;
            end
            c_HALT: begin
                // A timeout fault pins the sequencer here until reset.
                w_state_next = (run && !r_fault) ? c_FETCH : c_HALT;
            end
            default: begin
                w_state_next = c_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory wait counter: restarts on every state change or completed access
    // ------------------------------------------------------------------
    always_comb begin
        w_wait_next = r_wait;
        if (mem_ready || (w_state_next != r_state)) begin
            w_wait_next = 8'd0;
        end else if (w_mem_wait && (r_wait != FETCH_TIMEOUT)) begin
            w_wait_next = r_wait + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_FETCH;
            r_op    <= c_OP_NOP;
            r_wait  <= 8'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
            if (r_state == c_DECODE) begin
                r_op <= op;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode; everything is held low while reset is asserted
    // ------------------------------------------------------------------
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCBranch = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegR1    = 1'b0;
        RegR2    = 1'b0;
        RegW1    = 1'b0;
        RegW2    = 1'b0;
        ALUsrc   = 1'b0;
        writeCR  = 1'b0;
        cmpeq    = 1'b0;
        cmpne    = 1'b0;
        backup   = 1'b0;
        restore  = 1'b0;
        Regsrc   = c_SRC_ALU;
        ALUop    = c_ALU_ADD;
        halted   = 1'b0;
        fault    = 1'b0;
        if (!reset) begin
            fault = r_fault;
            case (r_state)
                c_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                c_DECODE: begin
                    RegR1 = 1'b1;
                    RegR2 = 1'b1;
                end
                c_EXEC: begin
                    case (r_op)
                        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR: begin
                            ALUop = r_op[2:0];
                        end
                        c_OP_ADDI, c_OP_LW, c_OP_SW: begin
                            ALUsrc = 1'b1;
                            ALUop  = c_ALU_ADD;
                        end
                        c_OP_SLT: begin
                            ALUop   = c_ALU_SLT;
                            writeCR = 1'b1;
                        end
                        c_OP_IN, c_OP_OUT: begin
                            // Port transfers need no strobes here; IN writes back in WB.
                            RegW2 = 1'b0;
                        end
                        c_OP_CMPEQ, c_OP_CMPNE: begin
                            ALUop    = c_ALU_SUB;
                            cmpeq    = (r_op == c_OP_CMPEQ);
                            cmpne    = (r_op == c_OP_CMPNE);
                            PCBranch = cmp_result;
                            PCWrite  = cmp_result;
                        end
                        c_OP_CALL: begin
                            backup   = 1'b1;
                            PCWrite  = 1'b1;
                            PCBranch = 1'b1;
                        end
                        c_OP_RET: begin
                            restore = 1'b1;
                            Regsrc  = c_SRC_RA;
                            RegW1   = 1'b1;
                        end
                        default: begin
                            ALUop = c_ALU_ADD;
                        end
                    endcase
                end
                c_MEM: begin
                    MemRead  = (r_op == c_OP_LW);
                    MemWrite = (r_op == c_OP_SW);
                end
                c_WB: begin
                    RegW1 = 1'b1;
                    case (r_op)
                        c_OP_LW: Regsrc = c_SRC_MEM;
                        c_OP_IN: Regsrc = c_SRC_IO;
                        default: Regsrc = c_SRC_ALU;
                    endcase
                end
                c_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ies_control_fsm.sv
`default_nettype none
// Directed, table-driven bench for ies_control_fsm; one table row per clock cycle.
module tb_ies_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] op = 4'h0;
    logic       cmp_result = 1'b0;
    logic       mem_ready = 1'b0;
    logic       run = 1'b0;
    logic       IRWrite, PCWrite, PCBranch, MemRead, MemWrite;
    logic       RegR1, RegR2, RegW1, RegW2, ALUsrc, writeCR;
    logic       cmpeq, cmpne, backup, restore, halted, fault;
    logic [1:0] Regsrc;
    logic [2:0] ALUop;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ies_control_fsm #(.FETCH_TIMEOUT(8'd255)) dut (
        .clk(clk), .reset(reset), .op(op), .cmp_result(cmp_result),
        .mem_ready(mem_ready), .run(run),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCBranch(PCBranch),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .RegR1(RegR1), .RegR2(RegR2), .RegW1(RegW1), .RegW2(RegW2),
        .ALUsrc(ALUsrc), .writeCR(writeCR), .cmpeq(cmpeq), .cmpne(cmpne),
        .backup(backup), .restore(restore), .Regsrc(Regsrc), .ALUop(ALUop),
        .halted(halted), .fault(fault)
    );

    // Output vector layout used by every expected value below
    localparam logic [21:0] IRW  = 22'd1 << 21;
    localparam logic [21:0] PCW  = 22'd1 << 20;
    localparam logic [21:0] PCB  = 22'd1 << 19;
    localparam logic [21:0] MR   = 22'd1 << 18;
    localparam logic [21:0] MW   = 22'd1 << 17;
    localparam logic [21:0] RR   = (22'd1 << 16) | (22'd1 << 15);
    localparam logic [21:0] RW1  = 22'd1 << 14;
    localparam logic [21:0] ASRC = 22'd1 << 12;
    localparam logic [21:0] WCR  = 22'd1 << 11;
    localparam logic [21:0] CEQ  = 22'd1 << 10;
    localparam logic [21:0] CNE  = 22'd1 << 9;
    localparam logic [21:0] BKP  = 22'd1 << 8;
    localparam logic [21:0] RST  = 22'd1 << 7;
    localparam logic [21:0] S_IO = 22'd1 << 5;
    localparam logic [21:0] S_MM = 22'd2 << 5;
    localparam logic [21:0] S_RA = 22'd3 << 5;
    localparam logic [21:0] A_SB = 22'd1 << 2;
    localparam logic [21:0] A_AN = 22'd2 << 2;
    localparam logic [21:0] A_SL = 22'd4 << 2;
    localparam logic [21:0] HLT  = 22'd1 << 1;
    localparam logic [21:0] FLT  = 22'd1;
    localparam logic [21:0] FET  = IRW | PCW | MR;
    localparam logic [21:0] NONE = 22'd0;

    typedef struct {
        logic [3:0]  op;
        logic        cmp;
        logic        mr;
        logic        run;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [21:0] outs();
        return {IRWrite, PCWrite, PCBranch, MemRead, MemWrite, RegR1, RegR2,
                RegW1, RegW2, ALUsrc, writeCR, cmpeq, cmpne, backup, restore,
                Regsrc, ALUop, halted, fault};
    endfunction

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] got;
        got = outs();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] o, input logic c, input logic m,
                       input logic r, input logic [21:0] e);
        vec_t v;
        v.op = o; v.cmp = c; v.mr = m; v.run = r; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic step(input string name, input logic [3:0] o, input logic c,
                        input logic m, input logic r, input logic [21:0] e);
        @(negedge clk);
        op = o; cmp_result = c; mem_ready = m; run = r;
        #1;
        check(name, e);
    endtask

    initial begin
        // ADD
        add(4'h0, 0, 1, 0, FET);  add(4'h0, 0, 0, 0, RR);
        add(4'h0, 0, 0, 0, NONE); add(4'h0, 0, 0, 0, RW1);
        // LW with three stalled MEM cycles
        add(4'h5, 0, 1, 0, FET);  add(4'h5, 0, 0, 0, RR);
        add(4'h5, 0, 0, 0, ASRC); add(4'h5, 0, 0, 0, MR);
        add(4'h5, 0, 0, 0, MR);   add(4'h5, 0, 0, 0, MR);
        add(4'h5, 0, 1, 0, MR);   add(4'h5, 0, 0, 0, RW1 | S_MM);
        // CMPEQ taken, then not taken
        add(4'hA, 0, 1, 0, FET);  add(4'hA, 0, 0, 0, RR);
        add(4'hA, 1, 0, 0, CEQ | A_SB | PCB | PCW);
        add(4'hA, 0, 1, 0, FET);  add(4'hA, 0, 0, 0, RR);
        add(4'hA, 0, 0, 0, CEQ | A_SB);
        // CALL, RET
        add(4'hC, 0, 1, 0, FET);  add(4'hC, 0, 0, 0, RR);
        add(4'hC, 0, 0, 0, BKP | PCW | PCB);
        add(4'hD, 0, 1, 0, FET);  add(4'hD, 0, 0, 0, RR);
        add(4'hD, 0, 0, 0, RST | S_RA | RW1);
        // CMPNE taken
        add(4'hB, 0, 1, 0, FET);  add(4'hB, 0, 0, 0, RR);
        add(4'hB, 1, 0, 0, CNE | A_SB | PCB | PCW);
        // SLT
        add(4'h7, 0, 1, 0, FET);  add(4'h7, 0, 0, 0, RR);
        add(4'h7, 0, 0, 0, A_SL | WCR);
        // SW, immediate ready
        add(4'h6, 0, 1, 0, FET);  add(4'h6, 0, 0, 0, RR);
        add(4'h6, 0, 0, 0, ASRC); add(4'h6, 0, 1, 0, MW);
        // IN
        add(4'h8, 0, 1, 0, FET);  add(4'h8, 0, 0, 0, RR);
        add(4'h8, 0, 0, 0, NONE); add(4'h8, 0, 0, 0, RW1 | S_IO);
        // OUT
        add(4'h9, 0, 1, 0, FET);  add(4'h9, 0, 0, 0, RR);
        add(4'h9, 0, 0, 0, NONE);
        // NOP
        add(4'hE, 0, 1, 0, FET);  add(4'hE, 0, 0, 0, RR);
        // SUB
        add(4'h1, 0, 1, 0, FET);  add(4'h1, 0, 0, 0, RR);
        add(4'h1, 0, 0, 0, A_SB); add(4'h1, 0, 0, 0, RW1);
        // HALT opcode, then resume with run
        add(4'hF, 0, 1, 0, FET);  add(4'hF, 0, 0, 0, RR);
        add(4'hF, 0, 0, 0, HLT);  add(4'hF, 0, 0, 1, HLT);
        // AND with one stalled fetch cycle
        add(4'h2, 0, 0, 0, MR);   add(4'h2, 0, 1, 0, FET);
        add(4'h2, 0, 0, 0, RR);   add(4'h2, 0, 0, 0, A_AN);
        add(4'h2, 0, 0, 0, RW1);

        // Reset state, before and after clock edges
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        check("reset_init", NONE);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", NONE);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_release", MR);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].op, tbl[i].cmp, tbl[i].mr,
                 tbl[i].run, tbl[i].exp);
        end

        // ADDI aborted by reset during WB
        step("addi_fetch", 4'h4, 0, 1, 0, FET);
        step("addi_decode", 4'h4, 0, 0, 0, RR);
        step("addi_exec", 4'h4, 0, 0, 0, ASRC);
        step("addi_wb", 4'h4, 0, 0, 0, RW1);
        #1 reset = 1'b1;
        #1;
        check("addi_wb_reset", NONE);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0; run = 1'b0;
        #1;
        check("post_abort_fetch", MR);

        // Fetch timeout: 254 waiting cycles stay in FETCH, the 255th halts
        repeat (254) @(posedge clk);
        @(negedge clk);
        #1;
        check("timeout_edge_minus1", MR);
        @(negedge clk);
        #1;
        check("timeout_fault", HLT | FLT);
        run = 1'b1; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("fault_ignores_run", HLT | FLT);
        reset = 1'b1;
        #1;
        check("fault_reset", NONE);
        @(negedge clk);
        reset = 1'b0; op = 4'hE; mem_ready = 1'b1; run = 1'b0;
        #1;
        check("fault_cleared_fetch", FET);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
